// File: rtl/bit_population_arbiter.sv
// Round-robin front end sharing one popcount unit among REQ_NUM clients.
// Requester IDs ride a tag pipeline matched to the counter latency and come back with each result.
module bit_population_arbiter #(
  parameter  int WIDTH       = 8,
  parameter  int REQ_NUM     = 4,
  parameter  int CNT_LATENCY = 2,
  localparam int CNT_W       = $clog2(WIDTH + 1),
  localparam int ID_W        = $clog2(REQ_NUM)
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     en_i,
  input  logic [REQ_NUM*WIDTH-1:0] req_data_i,
  input  logic [REQ_NUM-1:0]       req_val_i,
  output logic [REQ_NUM-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         cnt_data_o,
  output logic                     cnt_data_val_o,
  input  logic [CNT_W-1:0]         cnt_data_i,
  input  logic                     cnt_data_val_i,
  output logic [CNT_W-1:0]         resp_data_o,
  output logic [ID_W-1:0]          resp_id_o,
  output logic                     resp_val_o,
  output logic                     idle_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, gnt_id, issue_id;
  logic            gnt_any;
  logic [WIDTH-1:0] gnt_word;
  tag_t            tag_pipe [CNT_LATENCY];
  tag_t            tail;
  logic            tags_busy, pending;
  int              k;

  assign tail = tag_pipe[CNT_LATENCY-1];

  // Rotating priority search starting at ptr; only RUN may grant.
  always_comb begin
    req_ready_o = '0;
    gnt_any     = 1'b0;
    gnt_id      = '0;
    gnt_word    = '0;
    k           = 0;
    if (state == RUN) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        k = (int'(ptr) + i) % REQ_NUM;
        if (!gnt_any && req_val_i[k]) begin
          gnt_any  = 1'b1;
          gnt_id   = ID_W'(k);
          gnt_word = req_data_i[k*WIDTH +: WIDTH];
        end
      end
    end
    req_ready_o[gnt_id] = gnt_any;
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < CNT_LATENCY; i++) tags_busy = tags_busy | tag_pipe[i].vld;
  end

  // A word still sitting in the issue register counts as in flight.
  assign pending = tags_busy | cnt_data_val_o | resp_val_o;
  assign idle_o  = (state == IDLE) && !pending;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = RUN;
      RUN:     if (!en_i) state_nxt = DRAIN;
      DRAIN:   if (en_i) state_nxt = RUN;
               else if (!pending) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr            <= '0;
      issue_id       <= '0;
      cnt_data_o     <= '0;
      cnt_data_val_o <= 1'b0;
      resp_data_o    <= '0;
      resp_id_o      <= '0;
      resp_val_o     <= 1'b0;
      err_o          <= 1'b0;
      for (int i = 0; i < CNT_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      cnt_data_val_o <= gnt_any;
      if (gnt_any) begin
        cnt_data_o <= gnt_word;
        issue_id   <= gnt_id;
        ptr        <= (gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id + 1'b1;
      end
      tag_pipe[0] <= '{vld: cnt_data_val_o, id: issue_id};
      for (int i = 1; i < CNT_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      // Mismatch is flagged, but a counter strobe is still forwarded.
      if (cnt_data_val_i != tail.vld) err_o <= 1'b1;
      resp_val_o <= cnt_data_val_i;
      if (cnt_data_val_i) begin
        resp_data_o <= cnt_data_i;
        resp_id_o   <= tail.id;
      end
    end
  end

endmodule

// File: tb/tb_bit_population_arbiter.sv
// Directed bench: stimulus pushes expected grants/results, a negedge monitor pops and compares.
// A small popcount pipeline stands in for the external counter.
`timescale 1ns/1ps
module tb_bit_population_arbiter;
  localparam int WIDTH = 8, REQ_NUM = 4, L = 2;
  localparam int CNT_W = $clog2(WIDTH + 1), ID_W = $clog2(REQ_NUM);

  typedef struct {
    int id;
    int cnt;
    bit lat;
  } exp_t;

  logic                     clk = 0, arst = 0, en = 0;
  logic [REQ_NUM*WIDTH-1:0] req_data = '0;
  logic [REQ_NUM-1:0]       req_val = '0, req_ready;
  logic [WIDTH-1:0]         cnt_data_o;
  logic                     cnt_data_val_o, cnt_data_val_i, resp_val, idle, err;
  logic [CNT_W-1:0]         cnt_data_i, resp_data;
  logic [ID_W-1:0]          resp_id;
  logic                     inject = 0;
  logic [CNT_W-1:0]         inj_data = '0;

  int checks = 0, fails = 0, cyc = 0;
  exp_t exp_resp [$];
  int   exp_grant [$];
  int   gnt_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_population_arbiter #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .CNT_LATENCY(L)) dut (
    .clk_i(clk), .arst_i(arst), .en_i(en), .req_data_i(req_data), .req_val_i(req_val),
    .req_ready_o(req_ready), .cnt_data_o(cnt_data_o), .cnt_data_val_o(cnt_data_val_o),
    .cnt_data_i(cnt_data_i), .cnt_data_val_i(cnt_data_val_i), .resp_data_o(resp_data),
    .resp_id_o(resp_id), .resp_val_o(resp_val), .idle_o(idle), .err_o(err));

  // Stand-in popcount counter with fixed latency L, reset together with the DUT.
  logic             m_val [L];
  logic [CNT_W-1:0] m_cnt [L];
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < L; i++) begin m_val[i] <= 1'b0; m_cnt[i] <= '0; end
    end else begin
      m_val[0] <= cnt_data_val_o;
      m_cnt[0] <= CNT_W'($countones(cnt_data_o));
      for (int i = 1; i < L; i++) begin m_val[i] <= m_val[i-1]; m_cnt[i] <= m_cnt[i-1]; end
    end
  end
  assign cnt_data_val_i = m_val[L-1] | inject;
  assign cnt_data_i     = inject ? inj_data : m_cnt[L-1];

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor
  exp_t                e;
  int                  g;
  logic [REQ_NUM-1:0]  m;
  always @(negedge clk) begin
    if (!arst) begin
      if (req_ready != '0) begin
        check("ready_proto", int'($onehot(req_ready) && ((req_ready & ~req_val) == '0)), 1);
        if (exp_grant.size() == 0) check("grant_unexpected", int'(req_ready), 0);
        else begin
          m = '0;
          m[exp_grant.pop_front()] = 1'b1;
          check("grant_order", int'(req_ready), int'(m));
        end
        gnt_cyc.push_back(cyc);
      end
      if (resp_val) begin
        if (exp_resp.size() == 0) check("resp_unexpected", int'(resp_val), 0);
        else begin
          e = exp_resp.pop_front();
          check("resp_data", int'(resp_data), e.cnt);
          check("resp_id", int'(resp_id), e.id);
          if (e.lat) begin
            g = (gnt_cyc.size() != 0) ? gnt_cyc.pop_front() : -100;
            check("resp_latency", cyc - g, L + 2);
          end
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push(input int id, input int cnt);
    exp_grant.push_back(id);
    exp_resp.push_back('{id: id, cnt: cnt, lat: 1'b1});
  endtask

  task automatic chk_cleared();
    check("rst_cnt_val", int'(cnt_data_val_o), 0);
    check("rst_cnt_data", int'(cnt_data_o), 0);
    check("rst_resp_val", int'(resp_val), 0);
    check("rst_resp_data", int'(resp_data), 0);
    check("rst_resp_id", int'(resp_id), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(req_ready), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    arst = 1; en = 0; req_val = '1; inject = 0;
    tick(); tick();
    chk_cleared();
    exp_resp.delete(); exp_grant.delete(); gnt_cyc.delete();
    arst = 0; req_val = '0;
  endtask

  task automatic end_test(input string nm);
    for (int n = 0; n < 60 && exp_resp.size() != 0; n++) tick();
    repeat (3) tick();
    check({nm, "_resp_left"}, exp_resp.size(), 0);
    check({nm, "_grant_left"}, exp_grant.size(), 0);
  endtask

  initial begin
    // 1: single request from requester 2
    do_reset();
    en = 1; tick();
    req_data[2*WIDTH +: WIDTH] = 8'hFF; req_val = 4'b0100;
    push(2, 8);
    tick(); req_val = '0;
    end_test("single");

    // 2: all requesters held valid for 8 cycles
    do_reset();
    req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
    en = 1; tick();
    req_val = 4'hF;
    for (int r = 0; r < 2; r++) for (int q = 0; q < 4; q++) push(q, q + 1);
    repeat (8) tick();
    req_val = '0;
    end_test("all4");

    // 3: fairness between requesters 0 and 3
    do_reset();
    req_data = {8'h80, 8'h00, 8'h00, 8'hAA};
    en = 1; tick();
    req_val = 4'b1001;
    for (int r = 0; r < 3; r++) begin push(0, 4); push(3, 1); end
    repeat (6) tick();
    req_val = '0;
    end_test("fair");

    // 4: drain; en drops in the cycle of the third grant, requests stay up
    do_reset();
    req_data = {8'hFF, 8'h77, 8'h33, 8'h11};
    en = 1; tick();
    req_val = 4'hF;
    push(0, 2); push(1, 4); push(2, 6);
    tick(); tick();
    en = 0;
    repeat (5) tick();
    req_val = '0;
    for (int n = 0; n < 40 && !idle; n++) tick();
    check("drain_idle", int'(idle), 1);
    check("drain_all_returned", exp_resp.size(), 0);
    end_test("drain");

    // 5: spurious counter strobe with nothing in flight
    do_reset();
    tick();
    inj_data = 5; inject = 1;
    exp_resp.push_back('{id: 0, cnt: 5, lat: 1'b0});
    tick(); inject = 0;
    tick();
    check("err_set", int'(err), 1);
    repeat (5) tick();
    check("err_sticky", int'(err), 1);
    end_test("spurious");

    // 6: reset with two words in flight (do_reset also shows err cleared)
    do_reset();
    req_data = {8'h00, 8'h00, 8'h0F, 8'hFF};
    en = 1; tick();
    req_val = 4'b0011;
    exp_grant.push_back(0); exp_grant.push_back(1);
    tick(); tick();
    req_val = '0;
    check("inflight_before_rst", int'(cnt_data_val_o), 1);
    check("grants_before_rst", exp_grant.size(), 0);
    arst = 1; en = 0; #1;
    chk_cleared();
    tick();
    arst = 0;
    exp_resp.delete(); gnt_cyc.delete();
    repeat (10) tick();
    check("post_rst_idle", int'(idle), 1);
    end_test("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
